fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter for the async FIFO write domain. It shares the single FIFO write port (`we`/write data) among `NUM_REQ` requesters, grants bursts of up to `MAX_BURST` beats and stalls on `full`. It sits in the `wclk` domain in front of the write-pointer controller and consumes that controller's registered `full`/`h_full` flags.

---
 rtl/fifo_arb_pkg.sv | 10 +
 rtl/fifo_rr_pick.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 86 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state type and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/fifo_rr_pick.sv
// fifo_rr_pick: combinational rotate-priority picker, first requester at or after rr_ptr.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               valid,
  output logic [NUM_REQ-1:0] sel,
  output logic [IW-1:0]      idx
);
  logic [IW-1:0] j;
  // Scan farthest-first so the closest requester to rr_ptr is the last (winning) write.
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[j]) idx = j;
    end
  end
  assign valid = |req;
  assign sel = valid ? (NUM_REQ'(1) << idx) : '0;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the async FIFO write port.
// Optional FIFO_ARB_HFULL_THROTTLE_EN: no new burst starts while h_full is set.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 4,
  localparam int IW = idx_w(NUM_REQ),
  localparam int CW = cnt_w(MAX_BURST)
) (
  input  logic                          wclk,
  input  logic                          w_rstn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_in,
  input  logic                          full,
  input  logic                          h_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          we,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [IW-1:0]                 active_id
);
  state_t state, state_n;
  logic [NUM_REQ-1:0] gnt_n, sel;
  logic [IW-1:0] id_n, rr_ptr, ptr_n, idx;
  logic [CW-1:0] beat_cnt, cnt_n;
  logic valid, start, last, rel;
  fifo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(req),
    .rr_ptr(rr_ptr),
    .valid(valid),
    .sel(sel),
    .idx(idx)
  );
`ifdef FIFO_ARB_HFULL_THROTTLE_EN
  assign start = valid && !full && !h_full;
`else
  logic unused_h_full;
  assign unused_h_full = h_full;
  assign start = valid && !full;
`endif
  assign ack = gnt & req & {NUM_REQ{!full}};
  assign we = |ack;
  assign wdata = (|gnt) ? wdata_in[active_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign last = ack[active_id] && (beat_cnt == CW'(MAX_BURST - 1));
  // A drop on the same cycle as the last beat is still one release, one pointer advance.
  assign rel = last || !req[active_id];
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    id_n = active_id;
    ptr_n = rr_ptr;
    cnt_n = beat_cnt;
    if (state == IDLE) begin
      gnt_n = start ? sel : '0;
      if (start) begin
        id_n = idx;
        cnt_n = '0;
        state_n = BURST;
      end
    end else begin
      if (ack[active_id]) cnt_n = beat_cnt + 1'b1;
      if (rel) begin
        gnt_n = '0;
        ptr_n = (active_id == IW'(NUM_REQ - 1)) ? '0 : active_id + 1'b1;
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge wclk or negedge w_rstn) begin
    if (!w_rstn) begin
      state <= IDLE;
      gnt <= '0;
      active_id <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      active_id <= id_n;
      rr_ptr <= ptr_n;
      beat_cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for fifo_wr_arbiter (4 requesters, 8-bit data, bursts of 4).
module tb_fifo_wr_arbiter;
  logic wclk, w_rstn, full, h_full, we;
  logic [3:0] req, gnt, ack;
  logic [31:0] wdata_in;
  logic [7:0] wdata;
  logic [1:0] active_id;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .wclk(wclk), .w_rstn(w_rstn), .req(req), .wdata_in(wdata_in), .full(full),
    .h_full(h_full), .gnt(gnt), .ack(ack), .we(we), .wdata(wdata), .active_id(active_id)
  );

  initial wclk = 0;
  always #5 wclk = ~wclk;

  int n_chk = 0, n_fail = 0, n_beats = 0;
  logic [7:0] sb[$];
  int gq[$];
  logic [7:0] mem[4][16];
  int rd[4], cnt[4];
  logic [3:0] s_gnt, s_ack, prev_gnt;
  logic s_we;
  logic [7:0] s_wdata;

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i] = rd[i] < cnt[i];
      wdata_in[i*8 +: 8] = (rd[i] < cnt[i]) ? mem[i][rd[i]] : 8'h00;
    end
  endtask

  task automatic load(input int i, input int base, input int n);
    for (int k = 0; k < n; k++) mem[i][k] = 8'(base + k);
    rd[i] = 0;
    cnt[i] = n;
  endtask

  // One clock: sample at negedge, score writes and new grants, advance requesters on ack.
  task automatic cycle();
    logic [7:0] e;
    int g;
    @(negedge wclk);
    s_gnt = gnt; s_ack = ack; s_we = we; s_wdata = wdata;
    if (we) begin
      n_beats++;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: unexpected write of %0h, expected none", wdata);
      end else begin
        e = sb.pop_front();
        if (wdata !== e) begin
          n_fail++;
          $display("FAIL wdata: got %0h expected %0h", wdata, e);
        end
      end
    end
    if (gnt !== 4'b0 && prev_gnt === 4'b0) begin
      n_chk++;
      if (gq.size() == 0) begin
        n_fail++;
        $display("FAIL grant_unexpected: got id %0d expected no grant", active_id);
      end else begin
        g = gq.pop_front();
        if (active_id !== 2'(g) || gnt !== (4'b1 << g)) begin
          n_fail++;
          $display("FAIL grant_order: got id %0d gnt %b expected id %0d", active_id, gnt, g);
        end
      end
    end
    prev_gnt = gnt;
    @(posedge wclk);
    #1;
    for (int i = 0; i < 4; i++) if (s_ack[i]) rd[i]++;
    drive();
  endtask

  task automatic run_idle(input int max);
    int busy;
    bit done = 0;
    for (int k = 0; k < max && !done; k++) begin
      cycle();
      busy = 0;
      for (int i = 0; i < 4; i++) if (rd[i] < cnt[i]) busy++;
      if (busy == 0 && s_gnt === 4'b0 && sb.size() == 0) done = 1;
    end
    n_chk += 3;
    if (!done) begin n_fail++; $display("FAIL idle_timeout: got busy expected idle within %0d cycles", max); end
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d left expected 0", sb.size()); end
    if (gq.size() != 0) begin n_fail++; $display("FAIL gq_drain: got %0d left expected 0", gq.size()); end
  endtask

  task automatic do_reset();
    w_rstn = 0;
    full = 0;
    h_full = 0;
    for (int i = 0; i < 4; i++) begin rd[i] = 0; cnt[i] = 0; end
    drive();
    sb.delete();
    gq.delete();
    repeat (2) @(posedge wclk);
    #1;
    w_rstn = 1;
    prev_gnt = 0;
    n_beats = 0;
  endtask

  task automatic test_reset();
    w_rstn = 0; full = 0; h_full = 0;
    req = 4'b1111; wdata_in = 32'hFFFF_FFFF;
    @(posedge wclk); #1;
    n_chk += 7;
    if (gnt !== 4'b0) begin n_fail++; $display("FAIL rst_gnt: got %b expected 0000", gnt); end
    if (ack !== 4'b0) begin n_fail++; $display("FAIL rst_ack: got %b expected 0000", ack); end
    if (we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b expected 0", we); end
    if (wdata !== 8'h0) begin n_fail++; $display("FAIL rst_wdata: got %h expected 00", wdata); end
    if (active_id !== 2'd0) begin n_fail++; $display("FAIL rst_id: got %0d expected 0", active_id); end
    if (dut.rr_ptr !== 2'd0) begin n_fail++; $display("FAIL rst_ptr: got %0d expected 0", dut.rr_ptr); end
    if (dut.beat_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d expected 0", dut.beat_cnt); end
    do_reset();
  endtask

  task automatic test_single_burst();
    bit ew[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    bit eg[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    do_reset();
    load(0, 8'hA0, 6);
    for (int k = 0; k < 6; k++) sb.push_back(8'(8'hA0 + k));
    gq.push_back(0); gq.push_back(0);
    drive();
    for (int k = 0; k < 10; k++) begin
      cycle();
      n_chk += 2;
      if (s_we !== ew[k]) begin n_fail++; $display("FAIL single_we[%0d]: got %b expected %b", k, s_we, ew[k]); end
      if (s_gnt !== {3'b0, eg[k]}) begin n_fail++; $display("FAIL single_gnt[%0d]: got %b expected %b", k, s_gnt, {3'b0, eg[k]}); end
    end
    run_idle(10);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) load(i, i * 16, 8);
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < 4; i++) begin
        gq.push_back(i);
        for (int k = 0; k < 4; k++) sb.push_back(8'(i * 16 + h * 4 + k));
      end
    drive();
    run_idle(80);
    n_chk += 2;
    if (n_beats != 32) begin n_fail++; $display("FAIL rr_beats: got %0d expected 32", n_beats); end
    if (dut.rr_ptr !== 2'd0) begin n_fail++; $display("FAIL rr_wrap: got %0d expected 0", dut.rr_ptr); end
  endtask

  task automatic test_full_stall();
    do_reset();
    load(2, 8'hC0, 4);
    for (int k = 0; k < 4; k++) sb.push_back(8'(8'hC0 + k));
    gq.push_back(2);
    drive();
    for (int k = 0; k < 20 && n_beats < 2; k++) cycle();
    full = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_chk += 3;
      if (s_we !== 1'b0) begin n_fail++; $display("FAIL stall_we[%0d]: got %b expected 0", k, s_we); end
      if (s_gnt !== 4'b0100) begin n_fail++; $display("FAIL stall_gnt[%0d]: got %b expected 0100", k, s_gnt); end
      if (dut.beat_cnt !== 3'd2) begin n_fail++; $display("FAIL stall_cnt[%0d]: got %0d expected 2", k, dut.beat_cnt); end
    end
    full = 0;
    run_idle(20);
    n_chk += 2;
    if (n_beats != 4) begin n_fail++; $display("FAIL stall_beats: got %0d expected 4", n_beats); end
    if (dut.rr_ptr !== 2'd3) begin n_fail++; $display("FAIL stall_ptr: got %0d expected 3", dut.rr_ptr); end
  endtask

  task automatic test_req_drop();
    do_reset();
    load(1, 8'hB0, 1);
    load(3, 8'hD0, 2);
    sb.push_back(8'hB0); sb.push_back(8'hD0); sb.push_back(8'hD1);
    gq.push_back(1); gq.push_back(3);
    drive();
    for (int k = 0; k < 20 && n_beats < 1; k++) cycle();
    cycle();
    n_chk += 2;
    if (s_gnt !== 4'b0010) begin n_fail++; $display("FAIL drop_hold: got %b expected 0010", s_gnt); end
    if (s_we !== 1'b0) begin n_fail++; $display("FAIL drop_we: got %b expected 0", s_we); end
    cycle();
    n_chk += 2;
    if (s_gnt !== 4'b0000) begin n_fail++; $display("FAIL drop_gnt: got %b expected 0000", s_gnt); end
    if (dut.rr_ptr !== 2'd2) begin n_fail++; $display("FAIL drop_ptr: got %0d expected 2", dut.rr_ptr); end
    cycle();
    n_chk++;
    if (s_gnt !== 4'b1000) begin n_fail++; $display("FAIL drop_next: got %b expected 1000", s_gnt); end
    run_idle(20);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    load(2, 8'h20, 1);
    load(3, 8'hE0, 4);
    sb.push_back(8'h20); sb.push_back(8'hE0); sb.push_back(8'hE1);
    gq.push_back(2); gq.push_back(3);
    drive();
    for (int k = 0; k < 30 && n_beats < 3; k++) cycle();
    w_rstn = 0;
    #1;
    n_chk += 4;
    if (gnt !== 4'b0) begin n_fail++; $display("FAIL mid_rst_gnt: got %b expected 0000", gnt); end
    if (we !== 1'b0) begin n_fail++; $display("FAIL mid_rst_we: got %b expected 0", we); end
    if (wdata !== 8'h0) begin n_fail++; $display("FAIL mid_rst_wdata: got %h expected 00", wdata); end
    if (active_id !== 2'd0) begin n_fail++; $display("FAIL mid_rst_id: got %0d expected 0", active_id); end
    do_reset();
    load(0, 8'h10, 1);
    load(3, 8'h30, 1);
    sb.push_back(8'h10); sb.push_back(8'h30);
    gq.push_back(0); gq.push_back(3);
    drive();
    run_idle(20);
  endtask

  task automatic test_hfull();
    do_reset();
    load(0, 8'h55, 1);
    sb.push_back(8'h55);
    gq.push_back(0);
    h_full = 1;
    drive();
`ifdef FIFO_ARB_HFULL_THROTTLE_EN
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_chk++;
      if (s_gnt !== 4'b0) begin n_fail++; $display("FAIL hfull_block[%0d]: got %b expected 0000", k, s_gnt); end
    end
    h_full = 0;
`endif
    cycle();
    n_chk++;
    if (s_gnt !== 4'b0) begin n_fail++; $display("FAIL hfull_lat: got %b expected 0000", s_gnt); end
    cycle();
    n_chk++;
    if (s_gnt !== 4'b0001) begin n_fail++; $display("FAIL hfull_gnt: got %b expected 0001", s_gnt); end
    h_full = 0;
    run_idle(10);
  endtask

  initial begin
    prev_gnt = 0;
    for (int i = 0; i < 4; i++) begin rd[i] = 0; cnt[i] = 0; end
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_req_drop();
    test_reset_mid_burst();
    test_hfull();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
